dice_roller: RTL and testbench

//  Upstream of the board control path: turns the raw player key into a debounced roll request and

---
 rtl/dice_roller_pkg.sv | 16 +
 rtl/dice_roller_key_debounce.sv | 30 +++
 rtl/dice_roller.sv | 84 ++++++++
 tb/tb_dice_roller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dice_roller_pkg.sv
// dice_roller_pkg: shared FSM encoding, die width/limits and die-value helpers.
package dice_roller_pkg;
  localparam int DIE_W = 3;
  localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROLL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic logic usable(input logic [DIE_W-1:0] v);
    return v >= DIE_MIN && v <= DIE_MAX;
  endfunction
  // (v mod 6) + 1 for a 3-bit v: only 6 and 7 wrap.
  function automatic logic [DIE_W-1:0] fold(input logic [DIE_W-1:0] v);
    return v >= DIE_MAX ? v - DIE_MAX + DIE_MIN : v + DIE_MIN;
  endfunction
endpackage

// File: rtl/dice_roller_key_debounce.sv
// key_debounce: 2-flop synchronizer, stability debouncer and 1-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);
  logic [1:0]  sync;
  logic        level;
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= ~sync[1];
      end else cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: rtl/dice_roller.sv
// dice_roller: debounced key starts an animated LFSR dice roll, result held under valid/ack.
module dice_roller
  import dice_roller_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          ROLL_TICK       = 2500000,
  parameter int          ROLL_STEPS      = 12,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_n,
  input  logic             fast_fwd,
  input  logic             ack,
  output logic [DIE_W-1:0] d1,
  output logic [DIE_W-1:0] d2,
  output logic             rolling,
  output logic             roll_valid
);
  logic             press;
  logic [1:0]       state;
  logic [15:0]      lfsr;
  logic [31:0]      tick;
  logic [31:0]      step;
  logic             finish;
  logic             upd1;
  logic             upd2;
  logic             wrap;
  logic [DIE_W-1:0] c1;
  logic [DIE_W-1:0] c2;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(clk), .resetn(resetn), .key_n(key_n), .press(press)
  );
  assign c1         = lfsr[2:0];
  assign c2         = lfsr[5:3];
  assign wrap       = tick == 32'(ROLL_TICK - 1);
  assign rolling    = state == ROLL;
  assign roll_valid = state == DONE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      lfsr   <= LFSR_SEED;
      tick   <= '0;
      step   <= '0;
      finish <= 1'b0;
      upd1   <= 1'b0;
      upd2   <= 1'b0;
      d1     <= DIE_MIN;
      d2     <= DIE_MIN;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        IDLE: if (press) begin
          state  <= ROLL;
          tick   <= '0;
          step   <= '0;
          finish <= 1'b0;
          upd1   <= 1'b0;
          upd2   <= 1'b0;
        end
        // finish is registered at a tick wrap, so DONE follows one cycle later
        ROLL: if (finish) begin
          state <= DONE;
          if (!upd1) d1 <= fold(c1);
          if (!upd2) d2 <= fold(c2);
        end else if (wrap) begin
          tick   <= '0;
          step   <= step + 32'd1;
          finish <= fast_fwd || (step + 32'd1 == 32'(ROLL_STEPS));
          if (usable(c1)) begin
            d1   <= c1;
            upd1 <= 1'b1;
          end
          if (usable(c2)) begin
            d2   <= c2;
            upd2 <= 1'b1;
          end
        end else tick <= tick + 32'd1;
        DONE: if (ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: randomized and directed checks of dice_roller against a roll-level reference model.
module tb_dice_roller;
  localparam int          DB   = 4;
  localparam int          RT   = 3;
  localparam int          RS   = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 0, resetn = 0, key_n = 1, fast_fwd = 0, ack = 0;
  logic [2:0] d1, d2;
  logic rolling, roll_valid;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] m_lfsr;

  dice_roller #(.DEBOUNCE_CYCLES(DB), .ROLL_TICK(RT), .ROLL_STEPS(RS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .resetn(resetn), .key_n(key_n), .fast_fwd(fast_fwd), .ack(ack),
    .d1(d1), .d2(d2), .rolling(rolling), .roll_valid(roll_valid)
  );

  always #5 clk = ~clk;

  // Reference LFSR: new bit is XOR of 1-based positions 16,14,13,11, shifted in at the bottom.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or negedge resetn)
    if (!resetn) m_lfsr <= SEED;
    else m_lfsr <= lfsr_next(m_lfsr);

  always @(negedge clk)
    if (resetn) begin
      n_cmp++;
      if (d1 < 1 || d1 > 6 || d2 < 1 || d2 > 6) begin
        n_bad++;
        $display("FAIL die_range d1=%0d d2=%0d required 1..6", d1, d2);
      end
    end

  // Watches one roll and compares length and final dice against the model built from the
  // LFSR values seen in each rolling cycle.
  task automatic watch_roll(input bit ff);
    logic [15:0] q[$];
    logic [2:0] e1, e2;
    bit u1, u2;
    int lat, n, c, exp_len;
    e1 = d1; e2 = d2; u1 = 0; u2 = 0; lat = 0; n = 0;
    while (!rolling && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (!rolling || lat < 6 || lat > 8) begin
      n_bad++;
      $display("FAIL press_latency got %0d cycles rolling=%b, required 7+/-1 cycles", lat, rolling);
      return;
    end
    while (rolling && n < 100) begin q.push_back(m_lfsr); n++; @(negedge clk); end
    for (int i = 1; i < n; i++)
      if (i % RT == 0) begin
        c = int'(q[i-1][2:0]);
        if (c >= 1 && c <= 6) begin e1 = 3'(c); u1 = 1; end
        c = int'(q[i-1][5:3]);
        if (c >= 1 && c <= 6) begin e2 = 3'(c); u2 = 1; end
      end
    if (!u1) e1 = 3'(int'(q[n-1][2:0]) % 6 + 1);
    if (!u2) e2 = 3'(int'(q[n-1][5:3]) % 6 + 1);
    exp_len = ff ? RT : RS * RT;
    n_cmp++;
    if (n < exp_len - 1 || n > exp_len + 1) begin
      n_bad++;
      $display("FAIL roll_length got %0d cycles, required %0d+/-1", n, exp_len);
    end
    n_cmp++;
    if (roll_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL roll_valid_after_roll got %b, required 1", roll_valid);
    end
    n_cmp++;
    if ({d1, d2} !== {e1, e2}) begin
      n_bad++;
      $display("FAIL roll_result got d1=%0d d2=%0d, required d1=%0d d2=%0d", d1, d2, e1, e2);
    end
  endtask

  task automatic roll(input int hold, input bit ff);
    repeat (8) @(negedge clk);
    fast_fwd = ff;
    fork
      begin key_n = 0; repeat (hold) @(negedge clk); key_n = 1; end
      watch_roll(ff);
    join
  endtask

  task automatic do_ack();
    ack = 1;
    @(negedge clk);
    ack = 0;
    n_cmp++;
    if ({rolling, roll_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL ack_to_idle got rolling=%b roll_valid=%b, required 0 0", rolling, roll_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({d1, d2, rolling, roll_valid} !== {3'd1, 3'd1, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_state got d1=%0d d2=%0d rolling=%b valid=%b, required 1 1 0 0", d1, d2, rolling, roll_valid);
    end
    resetn = 1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({d1, d2, rolling, roll_valid} !== {3'd1, 3'd1, 2'b00}) begin
      n_bad++;
      $display("FAIL idle_after_reset got d1=%0d d2=%0d rolling=%b valid=%b, required 1 1 0 0", d1, d2, rolling, roll_valid);
    end
  endtask

  task automatic test_bounce();
    bit seen = 0;
    for (int i = 0; i < 24; i++) begin
      key_n = (i < 3 || (i >= 4 && i < 7)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rolling) seen = 1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_no_press got rolling seen=%b, required 0", seen);
    end
  endtask

  task automatic test_clean_roll();
    logic [2:0] h1, h2;
    roll(10, 0);
    h1 = d1; h2 = d2;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({roll_valid, d1, d2} !== {1'b1, h1, h2}) begin
      n_bad++;
      $display("FAIL hold_frozen got valid=%b d1=%0d d2=%0d, required 1 %0d %0d", roll_valid, d1, d2, h1, h2);
    end
    do_ack();
    n_cmp++;
    if ({d1, d2} !== {h1, h2}) begin
      n_bad++;
      $display("FAIL idle_keeps_dice got d1=%0d d2=%0d, required %0d %0d", d1, d2, h1, h2);
    end
  endtask

  task automatic test_fast_fwd();
    roll(10, 1);
    do_ack();
    fast_fwd = 0;
  endtask

  task automatic test_back_to_back();
    bit seen = 0, lost = 0;
    roll(30, 0);
    repeat (8) @(negedge clk);
    key_n = 0;
    repeat (12) begin @(negedge clk); if (rolling) seen = 1; if (!roll_valid) lost = 1; end
    key_n = 1;
    repeat (8) begin @(negedge clk); if (rolling) seen = 1; if (!roll_valid) lost = 1; end
    n_cmp++;
    if ({seen, lost} !== 2'b00) begin
      n_bad++;
      $display("FAIL press_in_done_dropped got rolling_seen=%b valid_lost=%b, required 0 0", seen, lost);
    end
    do_ack();
    ack = 1;
    repeat (3) @(negedge clk);
    ack = 0;
    repeat (15) begin @(negedge clk); if (rolling || roll_valid) seen = 1; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_stays_idle got activity=%b, required 0", seen);
    end
  endtask

  task automatic test_reset_midroll();
    int t = 0;
    repeat (8) @(negedge clk);
    key_n = 0;
    while (!rolling && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (rolling !== 1'b1) begin
      n_bad++;
      $display("FAIL midroll_start got rolling=%b, required 1", rolling);
    end
    @(negedge clk);
    resetn = 0;
    #1;
    n_cmp++;
    if ({d1, d2, rolling, roll_valid} !== {3'd1, 3'd1, 2'b00}) begin
      n_bad++;
      $display("FAIL midroll_reset got d1=%0d d2=%0d rolling=%b valid=%b, required 1 1 0 0", d1, d2, rolling, roll_valid);
    end
    key_n = 1;
    repeat (3) @(negedge clk);
    resetn = 1;
    roll(10, 0);
    do_ack();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      roll(int'($urandom_range(8, 20)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_ack();
    end
    fast_fwd = 0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_roll();
    test_fast_fwd();
    test_back_to_back();
    test_reset_midroll();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
